// File: rtl/audio_pkg.sv
// Shared audio types and constants for the codec receive path.
package audio_pkg;

    localparam int AUDIO_W = 32;

    typedef enum logic {CH_LEFT, CH_RIGHT} channel_t;

    typedef enum logic [1:0] {WAIT_SYNC, DELAY, SHIFT, PAD} i2s_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, plus a previous-value
// register so that rise and fall can be detected in the clock domain.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Capture the pin, settle metastability, and keep one cycle of history.
    // NOTE: flops use non-blocking assignments so every stage samples the
    // value from before this edge; blocking here would collapse the chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S / left-justified serial audio receiver. Assembles codec ADC bits into
// MSB-aligned 32-bit L/R samples and pulses audio_valid once per stereo pair.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 24,
    parameter bit I2S_MODE    = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                aud_bclk,
    input  logic                aud_adclrck,
    input  logic                aud_adcdat,
    output logic signed [31:0]  audio_out_L,
    output logic signed [31:0]  audio_out_R,
    output logic                audio_valid,
    output logic                frame_error
);

    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);

    logic bclk_level, bclk_rise, bclk_fall;
    logic lrck_level, lrck_rise, lrck_fall;
    logic dat_level, dat_rise, dat_fall;

    sync_edge u_sync_bclk (.clock(clock), .reset(reset), .pin(aud_bclk),
                           .level(bclk_level), .rise(bclk_rise), .fall(bclk_fall));
    sync_edge u_sync_lrck (.clock(clock), .reset(reset), .pin(aud_adclrck),
                           .level(lrck_level), .rise(lrck_rise), .fall(lrck_fall));
    sync_edge u_sync_dat  (.clock(clock), .reset(reset), .pin(aud_adcdat),
                           .level(dat_level), .rise(dat_rise), .fall(dat_fall));

    // Only the BCLK rise and the LRCK/data levels are used by the receiver.
    logic unused_edges;
    assign unused_edges = bclk_level | bclk_fall | lrck_rise | lrck_fall | dat_rise | dat_fall;

    i2s_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    channel_t               chan_q, chan_d;
    logic                   lrck_q, lrck_d;
    logic [AUDIO_W-1:0]     left_hold_q, left_hold_d;
    logic                   left_valid_q, left_valid_d;
    logic [AUDIO_W-1:0]     out_l_d, out_r_d;
    logic                   valid_d, ferr_d;

    logic                   lrck_edge;
    logic                   do_shift;
    logic [CNT_W-1:0]       cnt_next;
    logic [AUDIO_W-1:0]     aligned;

    // Next-state, word assembly and pair logic, evaluated on each BCLK rise.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        chan_d       = chan_q;
        lrck_d       = lrck_q;
        left_hold_d  = left_hold_q;
        left_valid_d = left_valid_q;
        out_l_d      = audio_out_L;
        out_r_d      = audio_out_R;
        valid_d      = 1'b0;
        ferr_d       = frame_error;
        lrck_edge    = bclk_rise && (lrck_level != lrck_q);
        do_shift     = 1'b0;
        cnt_next     = '0;
        aligned      = '0;

        if (bclk_rise) begin
            lrck_d = lrck_level;
            if (lrck_edge) begin
                // A channel change mid-word means the previous slot was short.
                if (state_q == SHIFT) begin
                    ferr_d       = 1'b1;
                    left_valid_d = 1'b0;
                end
                chan_d = lrck_level ? CH_RIGHT : CH_LEFT;
                // A new left slot supersedes any older left word.
                if (!lrck_level) begin
                    left_valid_d = 1'b0;
                end
                cnt_d = '0;
                if (I2S_MODE) begin
                    state_d = DELAY;
                end else begin
                    do_shift = 1'b1;
                end
            end else if (state_q == DELAY || state_q == SHIFT) begin
                do_shift = 1'b1;
            end
        end

        if (do_shift) begin
            shift_d  = {shift_q[SAMPLE_BITS-2:0], dat_level};
            cnt_next = cnt_d + 1'b1;
            cnt_d    = cnt_next;
            state_d  = SHIFT;
            if (cnt_next == CNT_W'(SAMPLE_BITS)) begin
                // Word complete; the counter then rests at SAMPLE_BITS in PAD.
                state_d = PAD;
                aligned = AUDIO_W'(shift_d) << (AUDIO_W - SAMPLE_BITS);
                if (chan_d == CH_LEFT) begin
                    left_hold_d  = aligned;
                    left_valid_d = 1'b1;
                end else if (left_valid_d) begin
                    out_l_d      = left_hold_q;
                    out_r_d      = aligned;
                    valid_d      = 1'b1;
                    left_valid_d = 1'b0;
                end
            end
        end
    end

    // State and datapath registers; outputs are registered here as well.
    // NOTE: the hold registers and outputs are reset explicitly so that a
    // reset mid-frame can never leak a stale half-pair downstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_SYNC;
            cnt_q        <= '0;
            shift_q      <= '0;
            chan_q       <= CH_LEFT;
            lrck_q       <= 1'b0;
            left_hold_q  <= '0;
            left_valid_q <= 1'b0;
            audio_out_L  <= '0;
            audio_out_R  <= '0;
            audio_valid  <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            chan_q       <= chan_d;
            lrck_q       <= lrck_d;
            left_hold_q  <= left_hold_d;
            left_valid_q <= left_valid_d;
            audio_out_L  <= out_l_d;
            audio_out_R  <= out_r_d;
            audio_valid  <= valid_d;
            frame_error  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: one I2S instance and one left-justified
// instance, each with its own pins and its own expected-pair queue.
module tb_i2s_rx;

    localparam int HALF = 163;  // BCLK half period, about 3.07 MHz
    localparam int FAST = 50;   // shortest legal half period (2.5 clocks)

    logic clock;
    logic reset;
    logic bclk_a, lrck_a, dat_a;
    logic bclk_b, lrck_b, dat_b;
    logic [31:0] out_l_a, out_r_a, out_l_b, out_r_b;
    logic valid_a, valid_b, ferr_a, ferr_b;

    i2s_rx #(.SAMPLE_BITS(24), .I2S_MODE(1'b1)) dut_a (
        .clock(clock), .reset(reset),
        .aud_bclk(bclk_a), .aud_adclrck(lrck_a), .aud_adcdat(dat_a),
        .audio_out_L(out_l_a), .audio_out_R(out_r_a),
        .audio_valid(valid_a), .frame_error(ferr_a)
    );

    i2s_rx #(.SAMPLE_BITS(24), .I2S_MODE(1'b0)) dut_b (
        .clock(clock), .reset(reset),
        .aud_bclk(bclk_b), .aud_adclrck(lrck_b), .aud_adcdat(dat_b),
        .audio_out_L(out_l_b), .audio_out_R(out_r_b),
        .audio_valid(valid_b), .frame_error(ferr_b)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    logic [63:0] sb_a[$];
    logic [63:0] sb_b[$];
    logic prev_valid_a = 1'b0;
    logic prev_valid_b = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
        checks++;
        if (act === bad) begin
            errors++;
            $display("FAIL %s: got %h which equals the rejected value %h", name, act, bad);
        end
    endtask

    // Scoreboard: compare each pulse against the oldest expected pair.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid_a <= 1'b0;
            prev_valid_b <= 1'b0;
        end else begin
            if (valid_a) begin
                pulses_a++;
                check("A pulse width", 64'(prev_valid_a), 64'(0));
                check("A pulse expected", 64'(sb_a.size() != 0), 64'(1));
                if (sb_a.size() != 0) begin
                    logic [63:0] e;
                    e = sb_a.pop_front();
                    check("A left", 64'(out_l_a), 64'(e[63:32]));
                    check("A right", 64'(out_r_a), 64'(e[31:0]));
                end
            end
            if (valid_b) begin
                pulses_b++;
                check("B pulse width", 64'(prev_valid_b), 64'(0));
                check("B pulse expected", 64'(sb_b.size() != 0), 64'(1));
                if (sb_b.size() != 0) begin
                    logic [63:0] e;
                    e = sb_b.pop_front();
                    check("B left", 64'(out_l_b), 64'(e[63:32]));
                    check("B right", 64'(out_r_b), 64'(e[31:0]));
                end
            end
            prev_valid_a <= valid_a;
            prev_valid_b <= valid_b;
        end
    end

    // One BCLK period: pins change with the falling edge, sampled on the rise.
    task automatic drive_bit(input bit lj, input bit lr, input bit d, input int half);
        if (lj) begin
            bclk_b = 1'b0; lrck_b = lr; dat_b = d;
        end else begin
            bclk_a = 1'b0; lrck_a = lr; dat_a = d;
        end
        #half;
        if (lj) bclk_b = 1'b1;
        else    bclk_a = 1'b1;
        #half;
    endtask

    // One channel slot of nbits BCLKs; delay slot and padding carry 1s.
    task automatic send_slot(input bit lj, input bit lr, input logic [23:0] w,
                             input int nbits, input int half);
        for (int b = 0; b < nbits; b++) begin
            logic d;
            d = 1'b1;
            if (lj) begin
                if (b < 24) d = w[23-b];
            end else begin
                if (b >= 1 && b <= 24) d = w[24-b];
            end
            drive_bit(lj, lr, d, half);
        end
    endtask

    task automatic send_frame(input bit lj, input logic [23:0] l, input logic [23:0] r,
                              input int slot, input int half);
        send_slot(lj, 1'b0, l, slot, half);
        send_slot(lj, 1'b1, r, slot, half);
    endtask

    // A full right slot gives the receiver its first LRCK edge without error.
    task automatic prime(input bit lj);
        send_slot(lj, 1'b1, 24'h000000, 32, HALF);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        repeat (2) @(negedge clock);
        check("reset A samples", {out_l_a, out_r_a}, 64'(0));
        check("reset A flags", {62'(0), valid_a, ferr_a}, 64'(0));
        check("reset B samples", {out_l_b, out_r_b}, 64'(0));
        check("reset B flags", {62'(0), valid_b, ferr_b}, 64'(0));
        reset = 1'b0;
    endtask

    typedef struct {
        bit          lj;
        logic [23:0] l;
        logic [23:0] r;
        int          slot;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int p0;
        logic [23:0] wl, wr;
        logic [31:0] shifted;

        tbl[0] = '{1'b0, 24'h7FFFFF, 24'h800000, 32, 32'h7FFFFF00, 32'h80000000};
        tbl[1] = '{1'b0, 24'h000001, 24'hFFFFFF, 25, 32'h00000100, 32'hFFFFFF00};
        tbl[2] = '{1'b1, 24'h123456, 24'hFEDCBA, 32, 32'h12345600, 32'hFEDCBA00};
        tbl[3] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 24, 32'hA5A5A500, 32'h5A5A5A00};

        bclk_a = 1'b0; lrck_a = 1'b0; dat_a = 1'b0;
        bclk_b = 1'b0; lrck_b = 1'b0; dat_b = 1'b0;
        #3;
        do_reset();

        // Nominal frames from the table, both modes, including minimum slots.
        prime(1'b0);
        prime(1'b1);
        for (int i = 0; i < 4; i++) begin
            p0 = tbl[i].lj ? pulses_b : pulses_a;
            if (tbl[i].lj) sb_b.push_back({tbl[i].exp_l, tbl[i].exp_r});
            else           sb_a.push_back({tbl[i].exp_l, tbl[i].exp_r});
            send_frame(tbl[i].lj, tbl[i].l, tbl[i].r, tbl[i].slot, HALF);
            repeat (4) @(negedge clock);
            check($sformatf("vec %0d pulse count", i),
                  64'((tbl[i].lj ? pulses_b : pulses_a) - p0), 64'(1));
            if (tbl[i].lj) begin
                wl = tbl[i].l;
                shifted = {wl[22:0], 1'b1, 8'h00};
                check_ne($sformatf("vec %0d one-bit-late model", i), 64'(out_l_b), 64'(shifted));
            end
        end
        check("nominal A frame_error", 64'(ferr_a), 64'(0));
        check("nominal B frame_error", 64'(ferr_b), 64'(0));

        // Reset released in the middle of a right slot, then three frames.
        reset = 1'b1;
        send_slot(1'b0, 1'b1, 24'h0F0F0F, 10, HALF);
        reset = 1'b0;
        send_slot(1'b0, 1'b1, 24'hFFFFFF, 22, HALF);
        p0 = pulses_a;
        for (int k = 0; k < 3; k++) begin
            wl = 24'($urandom());
            wr = 24'($urandom());
            sb_a.push_back({wl, 8'h00, wr, 8'h00});
            send_frame(1'b0, wl, wr, 32, HALF);
        end
        repeat (4) @(negedge clock);
        check("right-phase start pulses", 64'(pulses_a - p0), 64'(3));
        check("right-phase start queue", 64'(sb_a.size()), 64'(0));

        // Short left word: sticky error and no pulse for that frame.
        do_reset();
        prime(1'b0);
        p0 = pulses_a;
        send_slot(1'b0, 1'b0, 24'h111111, 10, HALF);
        send_slot(1'b0, 1'b1, 24'h222222, 32, HALF);
        repeat (4) @(negedge clock);
        check("short word frame_error", 64'(ferr_a), 64'(1));
        check("short word no pulse", 64'(pulses_a - p0), 64'(0));
        sb_a.push_back({32'h33333300, 32'h44444400});
        send_frame(1'b0, 24'h333333, 24'h444444, 32, HALF);
        sb_a.push_back({32'hC0FFEE00, 32'h0BADF000});
        send_frame(1'b0, 24'hC0FFEE, 24'h0BADF0, 32, HALF);
        repeat (4) @(negedge clock);
        check("short word recovery pulses", 64'(pulses_a - p0), 64'(2));
        check("short word error sticky", 64'(ferr_a), 64'(1));

        // Reset halfway through a right word abandons the pair.
        send_slot(1'b0, 1'b0, 24'h5555AA, 32, HALF);
        send_slot(1'b0, 1'b1, 24'hAA5555, 12, HALF);
        reset = 1'b1;
        #1;
        check("mid-frame reset samples", {out_l_a, out_r_a}, 64'(0));
        check("mid-frame reset flags", {62'(0), valid_a, ferr_a}, 64'(0));
        send_slot(1'b0, 1'b1, 24'hAA5555, 20, HALF);
        reset = 1'b0;
        prime(1'b0);
        p0 = pulses_a;
        for (int k = 0; k < 2; k++) begin
            wl = 24'($urandom());
            wr = 24'($urandom());
            sb_a.push_back({wl, 8'h00, wr, 8'h00});
            send_frame(1'b0, wl, wr, 32, HALF);
        end
        repeat (4) @(negedge clock);
        check("after reset pulses", 64'(pulses_a - p0), 64'(2));

        // Back-to-back random frames at minimum slot length and fast BCLK.
        p0 = pulses_a;
        for (int k = 0; k < 200; k++) begin
            wl = 24'($urandom());
            wr = 24'($urandom());
            sb_a.push_back({wl, 8'h00, wr, 8'h00});
            send_frame(1'b0, wl, wr, 25, FAST);
        end
        repeat (10) @(negedge clock);
        check("throughput pulses", 64'(pulses_a - p0), 64'(200));
        check("throughput queue A", 64'(sb_a.size()), 64'(0));
        check("final queue B", 64'(sb_b.size()), 64'(0));
        check("throughput frame_error", 64'(ferr_a), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
